imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ROM_SIZE_BIT, default 6, meaning word-address bits; depth = 2^ROM_SIZE_BIT 32-bit words.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port load_start  input  1  one-cycle pulse that begins or restarts a load.
REQ-005 SHALL have port load_end  input  1  one-cycle pulse that ends the byte stream.
REQ-006 SHALL have port byte_valid  input  1  byte_data is valid this cycle.
REQ-007 SHALL have port byte_data  input  8  stream byte, big-endian within each word.
REQ-008 SHALL have port byte_ready  output  1  the loader accepts a byte this cycle.
REQ-009 SHALL have port addr  input  32  CPU byte address; word index = addr[ROM_SIZE_BIT+1:2].
REQ-010 SHALL have port data  output  32  instruction word at addr, combinational.
REQ-011 SHALL have port busy  output  1  load in progress; the CPU is held while it is high.
REQ-012 SHALL have port done  output  1  last load completed cleanly.
REQ-013 SHALL have port error  output  1  last load ended on a partial word.
REQ-014 SHALL have port word_count  output  ROM_SIZE_BIT+1  number of words written by the current or last load.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, DONE and ERR; busy=1 only in LOAD, done=1 only in DONE, error=1 only in ERR.
REQ-016 SHALL assert byte_ready only in LOAD; byte_valid is ignored in every other state.
REQ-017 SHALL, on load_start in any state, enter LOAD next cycle with wr_addr=0, byte_cnt=0 and word_count=0, and any byte presented that cycle SHALL be discarded.
REQ-018 SHALL shift each accepted byte into the word assembler: the first byte lands in bits[31:24] and the fourth in bits[7:0].
REQ-019 SHALL, on the fourth byte, write the assembled word to memory[wr_addr] at that clock edge, then increment wr_addr and word_count and clear byte_cnt.
REQ-020 SHALL make a written word visible on data in the cycle after the write; a read of the same word in the write cycle returns the old contents.
REQ-021 SHALL move LOAD->DONE when the write to index 2^ROM_SIZE_BIT-1 occurs (memory full); later bytes are ignored and wr_addr does not wrap.
REQ-022 SHALL, on load_end in LOAD, first accept any byte presented in the same cycle, then go to DONE if the resulting byte_cnt==0, otherwise to ERR discarding the partial word.
REQ-023 SHALL ignore load_end outside LOAD; if load_start and load_end coincide, load_start SHALL win.
REQ-024 SHALL keep DONE and ERR until the next load_start.
REQ-025 SHALL leave data purely combinational from addr and the memory contents in every state; addr bits outside [ROM_SIZE_BIT+1:2] are ignored.

Reset
REQ-026 SHALL, when reset is low at a clock edge, enter state IDLE and set busy=0, done=0, error=0, byte_ready=0, word_count=0, wr_addr=0 and byte_cnt=0.
REQ-027 SHALL NOT clear memory contents on reset; a reset during LOAD abandons the load and keeps the words already written.

Structure
REQ-028 SHALL take the FSM state encoding and the default ROM_SIZE_BIT from the shared package cpu_defs.
REQ-029 SHALL instantiate the storage as one sub-module, imem_ram, with 1 synchronous write port and 1 asynchronous read port; the FSM and word assembler stay in imem_loader.

Verification
REQ-030 SHALL cover a basic load: load_start, bytes 8C,01,00,04,AC,02,00,08, then load_end -> word 0 = 0x8C010004, word 1 = 0xAC020008, done=1, word_count=2.
REQ-031 SHALL cover a partial word: load_start, bytes 12,34,56, then load_end -> error=1, word_count=0, word 0 unchanged.
REQ-032 SHALL cover fill to full: 256 bytes with ROM_SIZE_BIT=6 -> done=1 and word_count=64 after byte 256, byte_ready=0, and a 257th byte is ignored.
REQ-033 SHALL cover simultaneous events: the 4th byte arrives in the same cycle as load_end -> word written, done=1; load_start together with load_end in LOAD -> restart, busy=1, word_count=0.
REQ-034 SHALL cover reset mid-load: reset low after 5 bytes -> IDLE with all outputs 0, word 0 retained, addr=0x4 reads the old word 1.

Source files
------------

// File: rtl/cpu_defs.sv
// cpu_defs: shared loader FSM encoding and default instruction-ROM size
package cpu_defs;
    localparam int ROM_SIZE_BIT_DEF = 6;
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} load_state_t;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: instruction storage with a synchronous write port and an asynchronous read port, not cleared by reset
module imem_ram
    import cpu_defs::*;
#(
    parameter int AW = ROM_SIZE_BIT_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:(1<<AW)-1];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into words in instruction memory and serves CPU reads
module imem_loader
    import cpu_defs::*;
#(
    parameter int ROM_SIZE_BIT = ROM_SIZE_BIT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_end,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic [31:0]           addr,
    output logic [31:0]           data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ROM_SIZE_BIT:0] word_count
);
    load_state_t state, state_n;
    logic [ROM_SIZE_BIT-1:0] wr_addr;
    logic [1:0] byte_cnt;
    logic [23:0] shreg;
    logic accept, we, last;
    logic unused_addr;
    // a byte arriving with load_start belongs to the abandoned load
    assign accept = byte_ready && byte_valid && !load_start;
    assign we = accept && byte_cnt == 2'd3;
    assign last = we && &wr_addr;
    assign unused_addr = ^{addr[31:ROM_SIZE_BIT+2], addr[1:0]};
    assign busy = state == LOAD;
    assign byte_ready = busy;
    assign done = state == DONE;
    assign error = state == ERR;
    always_comb begin
        state_n = state;
        if (load_start) state_n = LOAD;
        else if (busy && last) state_n = DONE;
        else if (busy && load_end) state_n = (byte_cnt + 2'(accept)) == 2'd0 ? DONE : ERR;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            wr_addr <= '0;
            byte_cnt <= '0;
            word_count <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            if (load_start) begin
                wr_addr <= '0;
                byte_cnt <= '0;
                word_count <= '0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                shreg <= {shreg[15:0], byte_data};
                if (we) begin
                    wr_addr <= last ? wr_addr : wr_addr + ROM_SIZE_BIT'(1);
                    word_count <= word_count + (ROM_SIZE_BIT+1)'(1);
                end
            end
        end
    end
    imem_ram #(.AW(ROM_SIZE_BIT)) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(wr_addr),
        .wdata({shreg, byte_data}),
        .raddr(addr[ROM_SIZE_BIT+1:2]),
        .rdata(data)
    );
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus with a queued scoreboard checked by a negedge monitor
module tb_imem_loader;
    logic clk = 0, reset = 0, load_start = 0, load_end = 0, byte_valid = 0, byte_ready;
    logic [7:0] byte_data = 0;
    logic [31:0] addr = 0, data;
    logic busy, done, error;
    logic [6:0] word_count;
    typedef struct {string nm; int sel; logic [31:0] want;} exp_t;
    exp_t q[$];
    exp_t e;
    logic [31:0] act;
    int applied = 0, miscompares = 0;

    imem_loader dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_end(load_end),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .addr(addr), .data(data), .busy(busy), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // sel: 0 data, 1 {busy,done,error,byte_ready}, 2 word_count
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            act = e.sel == 0 ? data : e.sel == 1 ? {28'b0, busy, done, error, byte_ready} : {25'b0, word_count};
            applied++;
            if (act !== e.want) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.nm, act, e.want);
            end
        end
    end

    task automatic step(input logic ls, input logic le, input logic bv, input logic [7:0] bd);
        load_start = ls; load_end = le; byte_valid = bv; byte_data = bd;
        @(posedge clk); #1;
        load_start = 0; load_end = 0; byte_valid = 0; byte_data = 0;
    endtask

    task automatic chk(input string nm, input int sel, input logic [31:0] a, input logic [31:0] want);
        addr = a;
        q.push_back('{nm, sel, want});
        @(negedge clk); #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: monitor did not consume expectation", nm);
            q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b1 [8];
        b1 = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
        repeat (2) @(posedge clk);
        #1 reset = 1;
        chk("rst_status", 1, 0, 32'h0);
        chk("rst_wc", 2, 0, 32'd0);
        // basic load
        step(1, 0, 0, 0);
        chk("t1_busy", 1, 0, 32'b1001);
        chk("t1_wc0", 2, 0, 32'd0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, b1[i]);
        step(0, 1, 0, 0);
        chk("t1_done", 1, 0, 32'b0100);
        chk("t1_wc", 2, 0, 32'd2);
        chk("t1_w0", 0, 32'h0, 32'h8C010004);
        chk("t1_w1", 0, 32'h4, 32'hAC020008);
        step(0, 1, 0, 0);
        chk("t1_end_in_done", 1, 0, 32'b0100);
        // partial word
        step(1, 0, 0, 0);
        step(0, 0, 1, 8'h12);
        step(0, 0, 1, 8'h34);
        step(0, 0, 1, 8'h56);
        step(0, 1, 0, 0);
        chk("t2_err", 1, 0, 32'b0010);
        chk("t2_wc", 2, 0, 32'd0);
        chk("t2_w0", 0, 32'h0, 32'h8C010004);
        // fill to full
        step(1, 0, 0, 0);
        for (int i = 0; i < 255; i++) step(0, 0, 1, 8'(i));
        chk("t3_wc63", 2, 0, 32'd63);
        chk("t3_busy", 1, 0, 32'b1001);
        step(0, 0, 1, 8'hFF);
        chk("t3_done", 1, 0, 32'b0100);
        chk("t3_wc64", 2, 0, 32'd64);
        chk("t3_w63", 0, 32'hFC, 32'hFCFDFEFF);
        chk("t3_w0_hibits", 0, 32'h1000_0100, 32'h00010203);
        step(0, 0, 1, 8'hAA);
        chk("t3_extra_wc", 2, 0, 32'd64);
        chk("t3_extra_status", 1, 0, 32'b0100);
        chk("t3_extra_w63", 0, 32'hFC, 32'hFCFDFEFF);
        // 4th byte with load_end; start-cycle byte discarded
        step(1, 0, 1, 8'hFF);
        step(0, 0, 1, 8'h11);
        step(0, 0, 1, 8'h22);
        step(0, 0, 1, 8'h33);
        addr = 0;
        q.push_back('{"t4_old_in_write_cycle", 0, 32'h00010203});
        step(0, 1, 1, 8'h44);
        chk("t4_done", 1, 0, 32'b0100);
        chk("t4_wc", 2, 0, 32'd1);
        chk("t4_w0", 0, 32'h0, 32'h11223344);
        // start and end together in LOAD
        step(1, 0, 0, 0);
        step(0, 0, 1, 8'h55);
        step(1, 1, 0, 0);
        chk("t4_restart_status", 1, 0, 32'b1001);
        chk("t4_restart_wc", 2, 0, 32'd0);
        // reset mid-load
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'hA0 + 8'(i));
        chk("t5_wc1", 2, 0, 32'd1);
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
        chk("t5_status", 1, 0, 32'h0);
        chk("t5_wc", 2, 0, 32'd0);
        chk("t5_w0", 0, 32'h0, 32'hA0A1A2A3);
        chk("t5_w1", 0, 32'h4, 32'h04050607);
        step(0, 0, 1, 8'h77);
        chk("t5_idle_ignores", 1, 0, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
